// File: rtl/bsg_fifo_pkg.sv
// Shared FIFO helpers: pointer/count width functions and the last-op state encoding.
package bsg_fifo_pkg;

    // Width of a pointer that indexes els entries (at least 1 bit).
    function automatic int ptr_width_f(input int els);
        return (els <= 1) ? 1 : $clog2(els);
    endfunction

    // Width of an occupancy counter that must hold 0..els inclusive.
    function automatic int cnt_width_f(input int els);
        return $clog2(els + 1);
    endfunction

    // Which pointer moved last; disambiguates full from empty when the pointers are equal.
    typedef enum logic {
        e_last_deq = 1'b0,
        e_last_enq = 1'b1
    } last_op_e;

endpackage

// File: rtl/bsg_fifo_tracker_arn.sv
// Circular read/write pointer tracker with full/empty decode, async active-low reset.
module bsg_fifo_tracker_arn
    import bsg_fifo_pkg::*;
#(
    parameter int els_p        = 64,
    parameter int ptr_width_lp = ptr_width_f(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    enq_i,
    input  logic                    deq_i,
    output logic [ptr_width_lp-1:0] wptr_r_o,
    output logic [ptr_width_lp-1:0] rptr_r_o,
    output logic [ptr_width_lp-1:0] rptr_n_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

    logic [ptr_width_lp-1:0] wptr_r, rptr_r, wptr_n, rptr_n;
    last_op_e                last_op_r, last_op_n;

    // Next pointers wrap at els_p-1, so non-power-of-2 depths work; last op held when idle
    // or when both pointers move together.
    always_comb begin
        wptr_n    = wptr_r;
        rptr_n    = rptr_r;
        last_op_n = last_op_r;
        if (enq_i) wptr_n = (wptr_r == last_ptr_lp) ? '0 : wptr_r + 1'b1;
        if (deq_i) rptr_n = (rptr_r == last_ptr_lp) ? '0 : rptr_r + 1'b1;
        if (enq_i && !deq_i) last_op_n = e_last_enq;
        if (deq_i && !enq_i) last_op_n = e_last_deq;
    end

    // Pointer and last-op state; reset leaves the FIFO empty.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r    <= '0;
            rptr_r    <= '0;
            last_op_r <= e_last_deq;
        end else begin
            wptr_r    <= wptr_n;
            rptr_r    <= rptr_n;
            last_op_r <= last_op_n;
        end
    end

    assign wptr_r_o = wptr_r;
    assign rptr_r_o = rptr_r;
    assign rptr_n_o = rptr_n;
    assign full_o   = (wptr_r == rptr_r) && (last_op_r == e_last_enq);
    assign empty_o  = (wptr_r == rptr_r) && (last_op_r == e_last_deq);

endmodule

// File: rtl/bsg_fifo_1r1w_sync_read.sv
// Ready/valid 1R1W FIFO with a synchronous-read array and registered head data.
module bsg_fifo_1r1w_sync_read
    import bsg_fifo_pkg::*;
#(
    parameter int width_p      = 32,
    parameter int els_p        = 64,
    parameter int ptr_width_lp = ptr_width_f(els_p),
    parameter int cnt_width_lp = cnt_width_f(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    yumi_i,
    output logic [cnt_width_lp-1:0] count_o
);

    logic [ptr_width_lp-1:0] wptr_r, rptr_r, rptr_n;
    logic                    full, empty, enq, deq;
    logic [width_p-1:0]      mem [els_p];
    logic [width_p-1:0]      data_r;
    logic [cnt_width_lp-1:0] count_r;

    assign enq = v_i & ~full;
    assign deq = yumi_i;

    bsg_fifo_tracker_arn #(
        .els_p(els_p)
    ) tracker (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .enq_i    (enq),
        .deq_i    (deq),
        .wptr_r_o (wptr_r),
        .rptr_r_o (rptr_r),
        .rptr_n_o (rptr_n),
        .full_o   (full),
        .empty_o  (empty)
    );

    // Storage write; the array is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr_r] <= data_i;
    end

    // Head register reads ahead at the next read pointer; bypass covers the word being
    // written into the slot that becomes the head (write-to-empty, or slot just exposed).
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                 data_r <= '0;
        else if (enq && wptr_r == rptr_n) data_r <= data_i;
        else                            data_r <= mem[rptr_n];
    end

    // Occupancy: moves only when exactly one side transfers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)          count_r <= '0;
        else if (enq && !deq)    count_r <= count_r + cnt_width_lp'(1);
        else if (deq && !enq)    count_r <= count_r - cnt_width_lp'(1);
    end

    assign ready_o = ~full;
    assign v_o     = ~empty;
    assign data_o  = data_r;
    assign count_o = count_r;

    // Consumer must not take from an empty FIFO.
    a_no_yumi_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_i |-> !empty);

    // Occupancy stays consistent with the tracker's full/empty decode.
    a_count_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        empty |-> (count_r == '0) && (wptr_r == rptr_r));
    a_count_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        full |-> (count_r == cnt_width_lp'(els_p)) && (wptr_r == rptr_r));

endmodule

// File: tb/tb_bsg_fifo_1r1w_sync_read.sv
// Directed bench with a reference queue: accepted words are queued, and a monitor pops and
// compares every word the consumer takes.
module tb_bsg_fifo_1r1w_sync_read;

    localparam int W  = 32;
    localparam int N  = 64;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          v_i = 1'b0;
    logic          yumi_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          ready_o, v_o;
    logic [W-1:0]  data_o;
    logic [CW-1:0] count_o;

    int n_chk = 0;
    int n_fail = 0;
    int n_pop = 0;
    int pop_base;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    bsg_fifo_1r1w_sync_read #(.width_p(W), .els_p(N)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .v_i      (v_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .v_o      (v_o),
        .data_o   (data_o),
        .yumi_i   (yumi_i),
        .count_o  (count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare taken words against the queue, then record newly accepted words.
    always @(negedge clk) begin
        if (reset_n) begin
            if (v_o && yumi_i) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: got %0h expected no word", data_o);
                end else begin
                    chk("sb_data", data_o, sb.pop_front());
                end
                n_pop++;
            end
            if (v_i && ready_o) sb.push_back(data_i);
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_ready", ready_o, 1);
        chk("rst_v", v_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_data", data_o, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // 1: single push then pop
        v_i = 1; data_i = 32'hA5A5_0001; cyc(); v_i = 0;
        chk("t1_v", v_o, 1);
        chk("t1_data", data_o, 32'hA5A5_0001);
        chk("t1_count", count_o, 1);
        yumi_i = 1; cyc(); yumi_i = 0;
        chk("t1_v_after", v_o, 0);
        chk("t1_count_after", count_o, 0);

        // 2: fill, hold v_i while full, drain
        for (int i = 0; i < N; i++) begin
            v_i = 1; data_i = i; cyc();
        end
        chk("t2_ready_full", ready_o, 0);
        chk("t2_count_full", count_o, 64);
        data_i = 999;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_hold_count", count_o, 64);
            chk("t2_hold_ready", ready_o, 0);
        end
        chk("t2_head", data_o, 0);
        v_i = 0;
        pop_base = n_pop;
        yumi_i = 1; repeat (N) cyc(); yumi_i = 0;
        chk("t2_pops", n_pop - pop_base, 64);
        chk("t2_v_empty", v_o, 0);
        chk("t2_count_empty", count_o, 0);

        // 3: steady stream, pointers wrap repeatedly
        pop_base = n_pop;
        for (int c = 0; c < 200; c++) begin
            v_i = 1; data_i = 1000 + c; yumi_i = v_o; cyc();
            if (c > 0) chk("t3_count", count_o, 1);
        end
        v_i = 0; yumi_i = v_o; cyc(); yumi_i = 0;
        chk("t3_pops", n_pop - pop_base, 200);
        chk("t3_count_end", count_o, 0);

        // 4: full with simultaneous yumi and v_i
        for (int i = 0; i < N; i++) begin
            v_i = 1; data_i = 2000 + i; cyc();
        end
        chk("t4_ready_full", ready_o, 0);
        v_i = 1; data_i = 32'hDEAD; yumi_i = 1; cyc();
        v_i = 0; yumi_i = 0;
        chk("t4_ready", ready_o, 1);
        chk("t4_count", count_o, 63);
        chk("t4_head", data_o, 2001);
        yumi_i = 1; repeat (63) cyc(); yumi_i = 0;
        chk("t4_count_end", count_o, 0);

        // 5: bypass into empty, then into the slot just exposed
        v_i = 1; data_i = 32'h1234; cyc(); v_i = 0;
        chk("t5_data_a", data_o, 32'h1234);
        chk("t5_count_a", count_o, 1);
        v_i = 1; data_i = 32'h5678; yumi_i = 1; cyc(); v_i = 0; yumi_i = 0;
        chk("t5_data_b", data_o, 32'h5678);
        chk("t5_v_b", v_o, 1);
        chk("t5_count_b", count_o, 1);
        yumi_i = 1; cyc(); yumi_i = 0;
        chk("t5_count_end", count_o, 0);

        // 6: async reset mid-cycle with 10 entries
        for (int i = 0; i < 10; i++) begin
            v_i = 1; data_i = 3000 + i; cyc();
        end
        v_i = 0;
        chk("t6_count_pre", count_o, 10);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("t6_v", v_o, 0);
        chk("t6_ready", ready_o, 1);
        chk("t6_count", count_o, 0);
        chk("t6_data", data_o, 0);
        sb.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        v_i = 1; data_i = 32'hCAFE_F00D; cyc(); v_i = 0;
        chk("t6_v_post", v_o, 1);
        chk("t6_data_post", data_o, 32'hCAFE_F00D);
        chk("t6_count_post", count_o, 1);
        yumi_i = 1; cyc(); yumi_i = 0;
        chk("t6_count_end", count_o, 0);

        #2;
        chk("sb_leftover", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
